// File: rtl/sdma_channel_arbiter.sv
// sdma_channel_arbiter
//   Shares one SDMA channel between NUM_REQ level-sensitive requesters using
//   round-robin arbitration. A four-state FSM (IDLE, REQ, XFER, CMPL) issues
//   the channel request and waits for the channel to go active. It then waits
//   for the done pulse and reports completion or timeout to the granted
//   requester.
//
// Ports
//   WB_CLK          clock
//   WB_RST_n        asynchronous active-low reset
//   Enable_i        permits new grants (a transfer in flight always finishes)
//   Timeout_Val_i   per-transfer cycle limit, 0 disables the timeout
//   Req_i           level DMA requests, one bit per requester
//   Sreq_i          single-request qualifiers, one bit per requester
//   Grant_o         registered one-hot grant
//   Done_o          one-cycle completion pulse to the granted requester
//   Timeout_o       one-cycle timeout pulse to the granted requester
//   Busy_o          high whenever the FSM is not IDLE
//   SDMA_Req_o      channel request line
//   SDMA_Sreq_o     channel single-request line
//   SDMA_Active_i   channel active level
//   SDMA_Done_i     channel done pulse
module sdma_channel_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TO_W    = 16
) (
  input  logic               WB_CLK,
  input  logic               WB_RST_n,
  input  logic               Enable_i,
  input  logic [TO_W-1:0]    Timeout_Val_i,
  input  logic [NUM_REQ-1:0] Req_i,
  input  logic [NUM_REQ-1:0] Sreq_i,
  output logic [NUM_REQ-1:0] Grant_o,
  output logic [NUM_REQ-1:0] Done_o,
  output logic [NUM_REQ-1:0] Timeout_o,
  output logic               Busy_o,
  output logic               SDMA_Req_o,
  output logic               SDMA_Sreq_o,
  input  logic               SDMA_Active_i,
  input  logic               SDMA_Done_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_CMPL = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] tmo_q, tmo_d;
  logic               chreq_q, chreq_d;
  logic               chsreq_q, chsreq_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  // Held low for the first clock edge after reset release so that no grant
  // can be issued on that edge.
  logic               arm_q;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic [TO_W-1:0]    elapsed;
  logic               in_xfer;
  logic               tmo_hit;

  // Round-robin search beginning one past the last served requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && Req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // elapsed counts the REQ/XFER cycles spent so far, including the current
  // one. A limit of N therefore gives a grant lasting N cycles, and the
  // timeout pulse appears N cycles after the grant.
  assign elapsed = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + TO_W'(1);
  assign in_xfer = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign tmo_hit = in_xfer && (Timeout_Val_i != '0) && (elapsed == Timeout_Val_i);

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    grant_d  = grant_q;
    done_d   = '0;
    tmo_d    = '0;
    chreq_d  = chreq_q;
    chsreq_d = chsreq_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        grant_d  = '0;
        chreq_d  = 1'b0;
        chsreq_d = 1'b0;
        if (arm_q && Enable_i && found) begin
          state_d  = ST_REQ;
          gidx_d   = pick;
          grant_d  = NUM_REQ'(1) << pick;
          chreq_d  = 1'b1;
          chsreq_d = Sreq_i[pick];
          cnt_d    = '0;
        end
      end

      ST_REQ: begin
        cnt_d = elapsed;
        // Done outranks timeout, which outranks active, which outranks cancel.
        if (SDMA_Done_i) begin
          state_d  = ST_CMPL;
          done_d   = grant_q;
          chreq_d  = 1'b0;
          chsreq_d = 1'b0;
          last_d   = gidx_q;
        end else if (tmo_hit) begin
          state_d  = ST_IDLE;
          tmo_d    = grant_q;
          grant_d  = '0;
          chreq_d  = 1'b0;
          chsreq_d = 1'b0;
          last_d   = gidx_q;
        end else if (SDMA_Active_i) begin
          state_d  = ST_XFER;
          chreq_d  = 1'b0;
          chsreq_d = 1'b0;
        end else if (!Req_i[gidx_q]) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          chreq_d  = 1'b0;
          chsreq_d = 1'b0;
          last_d   = gidx_q;
        end
      end

      ST_XFER: begin
        cnt_d = elapsed;
        if (SDMA_Done_i) begin
          state_d = ST_CMPL;
          done_d  = grant_q;
          last_d  = gidx_q;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          tmo_d   = grant_q;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end

      ST_CMPL: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      state_q  <= ST_IDLE;
      gidx_q   <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      grant_q  <= '0;
      done_q   <= '0;
      tmo_q    <= '0;
      chreq_q  <= 1'b0;
      chsreq_q <= 1'b0;
      cnt_q    <= '0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      chreq_q  <= chreq_d;
      chsreq_q <= chsreq_d;
      cnt_q    <= cnt_d;
      arm_q    <= 1'b1;
    end
  end

  assign Grant_o     = grant_q;
  assign Done_o      = done_q;
  assign Timeout_o   = tmo_q;
  assign Busy_o      = (state_q != ST_IDLE);
  assign SDMA_Req_o  = chreq_q;
  assign SDMA_Sreq_o = chsreq_q;

endmodule

// File: tb/tb_sdma_channel_arbiter.sv
// tb_sdma_channel_arbiter
//   Directed-vector bench for sdma_channel_arbiter (NUM_REQ=4, TO_W=16).
//   Inputs change 1 time unit after a rising edge, and outputs are compared at
//   that same point.
module tb_sdma_channel_arbiter;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] tmo_val;
  logic [3:0]  req;
  logic [3:0]  sreq;
  logic [3:0]  grant;
  logic [3:0]  done_o;
  logic [3:0]  tmo_o;
  logic        busy;
  logic        ch_req;
  logic        ch_sreq;
  logic        active;
  logic        done;

  int n_cmp;
  int n_err;

  sdma_channel_arbiter #(.NUM_REQ(4), .TO_W(16)) dut (
    .WB_CLK        (clk),
    .WB_RST_n      (rst_n),
    .Enable_i      (enable),
    .Timeout_Val_i (tmo_val),
    .Req_i         (req),
    .Sreq_i        (sreq),
    .Grant_o       (grant),
    .Done_o        (done_o),
    .Timeout_o     (tmo_o),
    .Busy_o        (busy),
    .SDMA_Req_o    (ch_req),
    .SDMA_Sreq_o   (ch_sreq),
    .SDMA_Active_i (active),
    .SDMA_Done_i   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One round-robin transfer: wait for a grant, Active, then Done five
  // sampling edges later, CMPL, then the IDLE cycle.
  task automatic xfer_rr(input logic [3:0] exp, input logic [3:0] req_after);
    int n;
    n = 0;
    while (grant == 4'b0 && n < 16) begin
      tick();
      n++;
    end
    chk("rr_grant", grant, exp);
    chk("rr_chreq", ch_req, 1);
    chk("rr_chsreq", ch_sreq, 0);
    active = 1'b1;
    tick();
    active = 1'b0;
    chk("rr_chreq_drop", ch_req, 0);
    chk("rr_xfer_grant", grant, exp);
    repeat (4) tick();
    chk("rr_no_early_done", done_o, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("rr_done", done_o, exp);
    chk("rr_cmpl_grant", grant, exp);
    req = req_after;
    tick();
    chk("rr_done_once", done_o, 0);
    chk("rr_idle_grant", grant, 0);
    chk("rr_idle_busy", busy, 0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    enable  = 1'b1;
    tmo_val = 16'd0;
    req     = 4'b1111;
    sreq    = 4'b0000;
    active  = 1'b0;
    done    = 1'b0;

    // Reset state, with requests already pending.
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_done", done_o, 0);
    chk("rst_tmo", tmo_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chreq", ch_req, 0);
    chk("rst_chsreq", ch_sreq, 0);

    // Release: no grant on the first edge, requester 0 on the second.
    rst_n = 1'b1;
    tick();
    chk("arm_first_edge", grant, 0);
    tick();
    chk("first_grant", grant, 4'b0001);
    chk("first_busy", busy, 1);

    // Round robin with all four requesting.
    xfer_rr(4'b0001, 4'b1111);
    xfer_rr(4'b0010, 4'b1111);
    xfer_rr(4'b0100, 4'b1111);
    xfer_rr(4'b1000, 4'b1111);
    xfer_rr(4'b0001, 4'b0000);

    // Single requester 2 with its Sreq set. N is the current IDLE cycle.
    req  = 4'b0100;
    sreq = 4'b0100;
    tick();
    chk("s_grant_n1", grant, 4'b0100);
    chk("s_chreq_n1", ch_req, 1);
    chk("s_chsreq_n1", ch_sreq, 1);
    tick();
    chk("s_chsreq_n2", ch_sreq, 1);
    tick();
    active = 1'b1;
    tick();
    active = 1'b0;
    chk("s_chreq_n4", ch_req, 0);
    chk("s_chsreq_n4", ch_sreq, 0);
    chk("s_grant_n4", grant, 4'b0100);
    req = 4'b0000;
    tick();
    chk("s_xfer_ignores_req", grant, 4'b0100);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("s_done", done_o, 4'b0100);
    tick();
    chk("s_idle_grant", grant, 0);

    // Channel strobes while IDLE have no effect.
    done   = 1'b1;
    active = 1'b1;
    tick();
    done   = 1'b0;
    active = 1'b0;
    chk("idle_strobe_busy", busy, 0);
    chk("idle_strobe_done", done_o, 0);

    // Timeout of 10 with Active never asserted. The pointer sits at 2, so
    // requester 3 wins, and requester 0 follows.
    req     = 4'b1001;
    tmo_val = 16'd10;
    tick();
    chk("t_grant", grant, 4'b1000);
    chk("t_chsreq", ch_sreq, 0);
    repeat (9) tick();
    chk("t_no_early_tmo", tmo_o, 0);
    chk("t_chreq_held", ch_req, 1);
    tick();
    chk("t_tmo_pulse", tmo_o, 4'b1000);
    chk("t_grant_drop", grant, 0);
    chk("t_chreq_drop", ch_req, 0);
    chk("t_done_none", done_o, 0);
    tick();
    chk("t_next_grant", grant, 4'b0001);
    chk("t_tmo_once", tmo_o, 0);

    // Active and Done together on the third REQ cycle with a limit of 3.
    tmo_val = 16'd3;
    tick();
    tick();
    active = 1'b1;
    done   = 1'b1;
    tick();
    active = 1'b0;
    done   = 1'b0;
    chk("ad_done", done_o, 4'b0001);
    chk("ad_no_tmo", tmo_o, 0);
    chk("ad_cmpl_grant", grant, 4'b0001);
    req     = 4'b0010;
    tmo_val = 16'd0;
    tick();
    chk("ad_idle_tmo", tmo_o, 0);
    chk("ad_idle_grant", grant, 0);

    // Requester 1 drops its request before Active. Requester 1 then asserts
    // again together with requester 2, and 2 must win.
    tick();
    chk("c_grant", grant, 4'b0010);
    tick();
    req = 4'b0100;
    tick();
    chk("c_grant_drop", grant, 0);
    chk("c_chreq_drop", ch_req, 0);
    chk("c_no_done", done_o, 0);
    chk("c_busy", busy, 0);
    req = 4'b0110;
    tick();
    chk("c_pointer", grant, 4'b0100);
    active = 1'b1;
    tick();
    active = 1'b0;
    done   = 1'b1;
    tick();
    done = 1'b0;
    chk("c_done", done_o, 4'b0100);

    // Enable low blocks new grants only.
    req    = 4'b1111;
    enable = 1'b0;
    tick();
    tick();
    chk("en_block_grant", grant, 0);
    chk("en_block_busy", busy, 0);
    enable = 1'b1;
    tick();
    chk("en_grant", grant, 4'b1000);
    enable = 1'b0;
    active = 1'b1;
    tick();
    active = 1'b0;
    chk("en_xfer_grant", grant, 4'b1000);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("en_complete", done_o, 4'b1000);
    enable = 1'b1;
    tick();
    tick();
    chk("pre_rst_grant", grant, 4'b0001);
    active = 1'b1;
    tick();
    active = 1'b0;
    chk("pre_rst_busy", busy, 1);

    // Asynchronous reset in the middle of XFER.
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_busy", busy, 0);
    chk("ar_chreq", ch_req, 0);
    chk("ar_done", done_o, 0);
    chk("ar_tmo", tmo_o, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("ar_no_done", done_o, 0);
    rst_n = 1'b1;
    tick();
    chk("ar_arm_edge", grant, 0);
    tick();
    chk("ar_first_grant", grant, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
